// File: rtl/cla_adder_pipe_pkg.sv
// Shared types and 4-bit lookahead helpers for the pipelined CLA adder.
// Group P/G and the internal carries are separate functions so P/G never depends on carry-in.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic pg_t cla4_pg(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] g;
    pg_t        r;
    p   = a ^ b;
    g   = a & b;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  function automatic logic [3:0] cla4_carry(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Valid/ready operand and result stream for cla_adder_pipe.
interface cla_adder_pipe_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

endinterface

// File: rtl/cla_adder_pipe_group.sv
// Combinational 4-bit carry-lookahead group: sum plus group propagate/generate.
module cla_group
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       p,
  output logic       g
);

  pg_t pg;

  assign pg = cla4_pg(a, b);
  assign p  = pg.p;
  assign g  = pg.g;
  assign s  = a ^ b ^ cla4_carry(a, b, cin);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one SW-bit slice per stage, global-stall flow control.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  cla_adder_pipe_if.slave bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / CLA_GROUP;

  if (STAGES < 1 || STAGES > WIDTH / CLA_GROUP || (WIDTH % (STAGES * CLA_GROUP)) != 0) begin : g_bad_cfg
    $error("cla_adder_pipe: WIDTH must be a multiple of STAGES*4 and 1 <= STAGES <= WIDTH/4");
  end

  // Column k holds one beat: operands, the sum bits of slices below k, the carry into slice k.
  logic [WIDTH-1:0] a_q [STAGES+1];
  logic [WIDTH-1:0] b_q [STAGES+1];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic             c_q [STAGES+1];
  logic             v_q [STAGES+1];

  logic [SW-1:0]    sl_sum [STAGES];
  logic             sl_co  [STAGES];
  logic             en;

  assign en            = !v_q[STAGES] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[STAGES];
  assign bus.s         = s_q[STAGES];
  assign bus.cout      = c_q[STAGES];
  // Carry into the MSB recovered as a^b'^s at that bit.
  assign bus.ovf       = a_q[STAGES][WIDTH-1] ^ b_q[STAGES][WIDTH-1] ^ s_q[STAGES][WIDTH-1] ^ c_q[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic [SW-1:0] sum;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group u_grp (
        .a   (a_q[k][k*SW + j*CLA_GROUP +: CLA_GROUP]),
        .b   (b_q[k][k*SW + j*CLA_GROUP +: CLA_GROUP]),
        .cin (gc[j]),
        .s   (sum[j*CLA_GROUP +: CLA_GROUP]),
        .p   (gp[j]),
        .g   (gg[j])
      );
    end

    // Second-level lookahead: each group carry is a flat sum of products over group P/G.
    always_comb begin
      logic term;
      term  = 1'b0;
      gc    = '0;
      gc[0] = c_q[k];
      for (int unsigned j = 1; j <= NG; j++) begin
        term = c_q[k];
        for (int unsigned i = 0; i < j; i++) term = term & gp[i];
        gc[j] = term;
        for (int unsigned i = 0; i < j; i++) begin
          term = gg[i];
          for (int unsigned m = i + 1; m < j; m++) term = term & gp[m];
          gc[j] = gc[j] | term;
        end
      end
    end

    assign sl_sum[k] = sum;
    assign sl_co[k]  = gc[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (en) begin
      a_q[0] <= bus.a;
      b_q[0] <= bus.b ^ {WIDTH{bus.sub}};
      s_q[0] <= '0;
      c_q[0] <= bus.cin ^ bus.sub;
      v_q[0] <= bus.in_valid;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
        s_q[k+1] <= s_q[k] | (WIDTH'(sl_sum[k]) << (k * SW));
        c_q[k+1] <= sl_co[k];
        v_q[k+1] <= v_q[k];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: 32-bit/4-stage and 8-bit/1-stage instances.
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_adder_pipe_if #(.WIDTH(32)) bus32 ();
  cla_adder_pipe_if #(.WIDTH(8))  bus8 ();

  cla_adder_pipe #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  cla_adder_pipe #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic sub, output logic [31:0] s, output logic c,
                                output logic o);
    logic [31:0] bb;
    logic [32:0] r;
    bb = b ^ {32{sub}};
    r  = {1'b0, a} + {1'b0, bb} + 33'(cin ^ sub);
    s  = r[31:0];
    c  = r[32];
    o  = (a[31] == bb[31]) && (r[31] != a[31]);
  endfunction

  task automatic send(input bit w8, input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input logic [31:0] es, input logic ec, input logic eo,
                      input int lat);
    int   n;
    exp_t e;
    @(negedge clk);
    if (w8) begin
      bus8.in_valid = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; bus8.sub = sub;
    end else begin
      bus32.in_valid = 1'b1; bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub;
    end
    n = 0;
    #1;
    while (!(w8 ? bus8.in_ready : bus32.in_ready) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
    end else begin
      e.s = es; e.c = ec; e.o = eo; e.acc = cyc; e.lat = lat;
      if (w8) q8.push_back(e); else q32.push_back(e);
    end
    @(posedge clk); #1;
    if (w8) bus8.in_valid = 1'b0; else bus32.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    logic [31:0] es;
    logic        ec;
    logic        eo;
    model(a, b, cin, sub, es, ec, eo);
    send(1'b0, a, b, cin, sub, es, ec, eo, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d/%0d beats still pending, required 0", q32.size(), q8.size());
    end
  endtask

  always begin
    @(negedge clk); #2;
    if (!rst && bus32.out_valid) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL out32_unexpected: got s=%h with no beat pending", bus32.s);
      end else begin
        chk("s32", bus32.s, q32[0].s);
        chk("cout32", 32'(bus32.cout), 32'(q32[0].c));
        chk("ovf32", 32'(bus32.ovf), 32'(q32[0].o));
        if (bus32.out_ready) begin
          if (q32[0].lat != 0) chk("lat32", 32'(cyc - q32[0].acc), 32'(q32[0].lat));
          void'(q32.pop_front());
        end
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (!rst && bus8.out_valid) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL out8_unexpected: got s=%h with no beat pending", bus8.s);
      end else begin
        chk("s8", 32'(bus8.s), q8[0].s);
        chk("cout8", 32'(bus8.cout), 32'(q8[0].c));
        chk("ovf8", 32'(bus8.ovf), 32'(q8[0].o));
        if (bus8.out_ready) begin
          if (q8[0].lat != 0) chk("lat8", 32'(cyc - q8[0].acc), 32'(q8[0].lat));
          void'(q8.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid32", 32'(bus32.out_valid), 32'h0);
    chk("rst_s32", bus32.s, 32'h0);
    chk("rst_cout32", 32'(bus32.cout), 32'h0);
    chk("rst_ovf32", 32'(bus32.ovf), 32'h0);
    chk("rst_out_valid8", 32'(bus8.out_valid), 32'h0);
    chk("rst_s8", 32'(bus8.s), 32'h0);
    rst = 1'b0;
    #1;
    chk("in_ready32_after_rst", 32'(bus32.in_ready), 32'h1);
    chk("in_ready8_after_rst", 32'(bus8.in_ready), 32'h1);

    // Directed 32-bit vectors, back to back, latency checked on every beat.
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5);
    send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 5);
    send(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 5);
    send(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 5);
    send(1'b0, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 5);
    send(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 5);
    send(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 5);
    send(1'b0, 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 5);
    send(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 5);
    send(1'b1, 32'h0000_00A5, 32'h0000_005B, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 2);
    wait_drain();

    // 16-beat stream with a stall window; results compared in order against the model.
    fork
      begin
        for (int i = 0; i < 16; i++)
          send_m($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(negedge clk);
        bus32.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus32.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Fill the pipe under backpressure, then reset with beats in flight.
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_m(32'h0000_1000 * i, 32'h0000_0011, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid32", 32'(bus32.out_valid), 32'h0);
    chk("midrst_s32", bus32.s, 32'h0);
    q32.delete();
    bus32.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready32_after_midrst", 32'(bus32.in_ready), 32'h1);
    send(1'b0, 32'h0000_0064, 32'h0000_0037, 1'b0, 1'b0, 32'h0000_009B, 1'b0, 1'b0, 5);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
